// File: rtl/multicycle_controller.sv
// Multicycle main controller for the RV64 R/LD/SD/BEQ datapath: steps each
// instruction through FETCH..WB, counts retirements and halts on illegal opcodes or memory timeouts.
module multicycle_controller #(
   parameter int unsigned RETIRE_WIDTH   = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [6:0]              opcode,
   input  logic                    memoryReady,
   output logic                    pcWrite,
   output logic                    pcWriteCond,
   output logic                    pcSource,
   output logic                    instructionOrData,
   output logic                    instructionWrite,
   output logic                    memoryRead,
   output logic                    memoryWrite,
   output logic                    memoryToRegister,
   output logic                    regWrite,
   output logic                    ALUSrcA,
   output logic [1:0]              ALUSrcB,
   output logic [1:0]              ALUOp,
   output logic                    instrRetired,
   output logic [RETIRE_WIDTH-1:0] retiredCount,
   output logic                    halted,
   output logic                    busError
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXECUTE, S_ALU_WB, S_MEM_ADDR,
      S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_HALT
   } state_t;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_SD = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   state_t                  state_q, state_d;
   logic [31:0]             wait_q, wait_d;
   logic                    busError_q, busError_d;
   logic [RETIRE_WIDTH-1:0] retired_q;
   logic                    waiting, timeout;

   always_comb begin
      waiting = ((state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE))
                && !memoryReady;
      // Fires on the wait cycle that brings the count up to the limit; a ready in that cycle is not a wait.
      timeout = waiting && (TIMEOUT_CYCLES != 0) && (wait_q == TIMEOUT_CYCLES - 1);

      state_d = state_q;
      unique case (state_q)
         S_FETCH:     if (memoryReady) state_d = S_DECODE;
         S_DECODE: begin
            unique case (opcode)
               OP_R:         state_d = S_EXECUTE;
               OP_LD, OP_SD: state_d = S_MEM_ADDR;
               OP_BEQ:       state_d = S_BRANCH;
               default:      state_d = S_HALT;
            endcase
         end
         S_EXECUTE:   state_d = S_ALU_WB;
         S_ALU_WB:    state_d = S_FETCH;
         S_MEM_ADDR:  state_d = (opcode == OP_LD) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  if (memoryReady) state_d = S_MEM_WB;
         S_MEM_WB:    state_d = S_FETCH;
         S_MEM_WRITE: if (memoryReady) state_d = S_FETCH;
         S_BRANCH:    state_d = S_FETCH;
         S_HALT:      state_d = S_HALT;
         default:     state_d = S_HALT;
      endcase
      if (timeout) state_d = S_HALT;

      busError_d = busError_q | timeout;
      wait_d     = (waiting && (state_d == state_q)) ? wait_q + 32'd1 : '0;
   end

   always_comb begin
      pcWrite           = 1'b0;
      pcWriteCond       = 1'b0;
      pcSource          = 1'b0;
      instructionOrData = 1'b0;
      instructionWrite  = 1'b0;
      memoryRead        = 1'b0;
      memoryWrite       = 1'b0;
      memoryToRegister  = 1'b0;
      regWrite          = 1'b0;
      ALUSrcA           = 1'b0;
      ALUSrcB           = 2'b00;
      ALUOp             = 2'b00;
      instrRetired      = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            // Reset gating keeps the PC and IR untouched while reset is held.
            pcWrite          = memoryReady & reset;
            instructionWrite = memoryReady & reset;
            memoryRead       = 1'b1;
            ALUSrcB          = 2'b01;
         end
         S_DECODE:   ALUSrcB = 2'b10;
         S_EXECUTE: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
         end
         S_ALU_WB: begin
            regWrite     = 1'b1;
            instrRetired = 1'b1;
         end
         S_MEM_ADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEM_READ: begin
            memoryRead        = 1'b1;
            instructionOrData = 1'b1;
         end
         S_MEM_WB: begin
            regWrite         = 1'b1;
            memoryToRegister = 1'b1;
            instrRetired     = 1'b1;
         end
         S_MEM_WRITE: begin
            memoryWrite       = 1'b1;
            instructionOrData = 1'b1;
            instrRetired      = memoryReady;
         end
         S_BRANCH: begin
            ALUSrcA      = 1'b1;
            ALUOp        = 2'b01;
            pcWriteCond  = 1'b1;
            pcSource     = 1'b1;
            instrRetired = 1'b1;
         end
         default: ;
      endcase
   end

   assign retiredCount = retired_q;
   assign halted       = (state_q == S_HALT);
   assign busError     = busError_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= S_FETCH;
         wait_q     <= '0;
         busError_q <= 1'b0;
         retired_q  <= '0;
      end else begin
         state_q    <= state_d;
         wait_q     <= wait_d;
         busError_q <= busError_d;
         if (instrRetired) retired_q <= retired_q + RETIRE_WIDTH'(1);
      end
   end

endmodule
